// File: rtl/test_ctrl_pkg.sv
// Shared types and default constants for the test control monitor.
package test_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [31:0] SIG_ADDR_DEF  = 32'h001F_FE68;
  localparam logic [31:0] HALT_ADDR_DEF = 32'h001F_FE6C;
  localparam int unsigned PASS_CODE     = 1;

endpackage

// File: rtl/test_ctrl_monitor_sig_fifo.sv
// Synchronous signature FIFO; a push into a full FIFO is accepted only when a pop
// frees the slot in the same cycle.
module sig_fifo
  import test_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic              do_push, do_pop;

  // Pointers carry a wrap bit: same index with differing wrap bits means full.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PTR_ONE;
    if (do_pop)  rptr_d = rptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

  // Storage is not reset, so the head is forced to zero while empty.
  assign data_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/test_ctrl_monitor.sv
// Store-channel snooper: signature capture, halt decode and watchdog for
// architecture tests.
//
// state | meaning
// RUN   | test executing; stores decoded, cycle counter running
// DRAIN | test ended; waiting for the signature FIFO to empty
// DONE  | terminal; results held until reset
module test_ctrl_monitor
  import test_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 16,
  parameter logic [ADDR_W-1:0] SIG_ADDR  = ADDR_W'(SIG_ADDR_DEF),
  parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(HALT_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              store_req_i,
  input  logic [ADDR_W-1:0] store_addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [CNT_W-1:0]  max_cycles_i,
  output logic [DATA_W-1:0] sig_data_o,
  output logic              sig_valid_o,
  input  logic              sig_ready_i,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [DATA_W-2:0] exit_code_o,
  output logic              overflow_o,
  output logic [CNT_W-1:0]  cycle_count_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-2:0] exit_q, exit_d;
  logic              ovf_q, ovf_d;

  logic in_run, sig_hit, halt_hit, wd_hit;
  logic fifo_full, fifo_empty, pop;

  assign in_run   = (state_q == RUN);
  assign sig_hit  = in_run && store_req_i && (store_addr_i == SIG_ADDR);
  assign halt_hit = in_run && store_req_i && (store_addr_i == HALT_ADDR);
  assign wd_hit   = in_run && (max_cycles_i != '0) && !halt_hit &&
                    (cnt_q == max_cycles_i - CNT_W'(1));
  assign pop      = sig_valid_o && sig_ready_i;

  sig_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (sig_hit),
    .data_i (store_data_i),
    .pop_i  (pop),
    .data_o (sig_data_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign sig_valid_o = !fifo_empty;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    exit_d    = exit_q;
    ovf_d     = ovf_q;

    if (sig_hit && fifo_full && !pop) ovf_d = 1'b1;

    case (state_q)
      RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (halt_hit) begin
          pass_d = (store_data_i == DATA_W'(PASS_CODE));
          exit_d = store_data_i[DATA_W-1:1];
        end else if (wd_hit) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
        // A word pushed on the timeout cycle still has to drain.
        if (halt_hit || wd_hit) state_d = (fifo_empty && !sig_hit) ? DONE : DRAIN;
      end
      DRAIN:   if (fifo_empty) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      exit_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      exit_q    <= exit_d;
      ovf_q     <= ovf_d;
    end
  end

  assign done_o        = (state_q == DONE);
  assign pass_o        = pass_q;
  assign timeout_o     = timeout_q;
  assign exit_code_o   = exit_q;
  assign overflow_o    = ovf_q;
  assign cycle_count_o = cnt_q;

endmodule

// File: doc/test_ctrl_monitor.md
Name: test_ctrl_monitor

Overview:
Synthesizable, parametrised successor to the bench-level signature, halt and timeout logic.
- Snoops the data-bus store channel of the MCU.
- Captures signature stores into a FIFO that is drained over a valid/ready port.
- Decodes a halt store into a pass/fail exit code.
- Runs a programmable-limit watchdog.
- Sits beside the memory/peripheral interconnect; used for architecture tests in simulation and on FPGA, where the FIFO is drained by a UART/JTAG dumper.

Parameters:
ADDR_W, 32, store address width
DATA_W, 32, store data / signature word width (>=2)
CNT_W, 32, cycle counter and limit width
FIFO_DEPTH, 16, signature FIFO entries (power of two, >=2)
SIG_ADDR, 32'h001FFE68, store address that pushes a signature word
HALT_ADDR, 32'h001FFE6C, store address that ends the test

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
store_req_i  in  1  store strobe, one store per cycle
store_addr_i  in  ADDR_W  store address
store_data_i  in  DATA_W  store write data
max_cycles_i  in  CNT_W  watchdog limit, 0 = disabled; held static after reset
sig_data_o  out  DATA_W  FIFO head word
sig_valid_o  out  1  FIFO non-empty
sig_ready_i  in  1  consumer accepts head word
done_o  out  1  test finished (sticky)
pass_o  out  1  halt data == 1 (sticky, valid when done_o)
timeout_o  out  1  ended by watchdog (sticky)
exit_code_o  out  DATA_W-1  store_data_i[DATA_W-1:1] captured at halt
overflow_o  out  1  signature word dropped (sticky)
cycle_count_o  out  CNT_W  cycles spent in RUN

Behaviour:
- Reset (asynchronous assert, synchronous release): state=RUN, FIFO empty, counter=0; every output is 0.
- FSM states:
  - RUN -> DRAIN on halt store or timeout.
  - DRAIN -> DONE when the FIFO is empty (same cycle if already empty).
  - DONE is terminal until reset.
- done_o=1 only in DONE, registered. The minimum is 1 cycle after the halt store when the FIFO is empty.
- Signature store:
  - store_req_i && store_addr_i==SIG_ADDR in RUN pushes store_data_i.
  - sig_valid_o/sig_data_o reflect the word the cycle after the push (1-cycle latency), in FIFO order.
- Pop occurs on sig_valid_o && sig_ready_i. sig_data_o is stable while sig_valid_o && !sig_ready_i.
- Push when full without a same-cycle pop: the word is dropped, overflow_o=1 sticky, FIFO unchanged.
- Push when full with a same-cycle pop: the push is accepted and the count stays at FIFO_DEPTH.
- Push and pop on an empty FIFO: the push is accepted and the pop does not occur (valid was 0).
- Halt store: store_req_i && store_addr_i==HALT_ADDR in RUN.
  - Latches pass_o=(store_data_i==1) and exit_code_o=store_data_i[DATA_W-1:1].
  - timeout_o stays 0.
- Watchdog:
  - In RUN, cycle_count increments every cycle and saturates at all-ones.
  - When max_cycles_i!=0 and cycle_count==max_cycles_i-1 with no halt that cycle, the next state is DRAIN with timeout_o=1 and pass_o=0.
  - Halt and timeout in the same cycle: halt wins.
- Stores in DRAIN or DONE, to any address, are ignored. Stores to other addresses are ignored in every state.
- cycle_count_o freezes on leaving RUN.
- Pointer wrap: read/write pointers are log2(FIFO_DEPTH) bits plus a wrap bit; full = same index with opposite wrap bits.
- Reset mid-drain discards FIFO contents and all sticky flags.

Decomposition:
- Package test_ctrl_pkg holds:
  - the state enum (RUN, DRAIN, DONE);
  - default SIG_ADDR/HALT_ADDR constants;
  - the PASS_CODE constant (1).
- One sub-module, sig_fifo: parametrised synchronous FIFO (DATA_W, FIFO_DEPTH) with push/pop/full/empty and the simultaneous push-on-full rule above.
- The FSM, address decode and watchdog stay in test_ctrl_monitor.

Test Plan:
- Pass test:
  - Stimulus: 3 stores to SIG_ADDR (0xA, 0xB, 0xC) with sig_ready_i=1, then a store of 1 to HALT_ADDR.
  - Response: words pop in order A, B, C; done_o=1, pass_o=1, exit_code_o=0, timeout_o=0.
- Fail code:
  - Stimulus: store of 0x0000000B to HALT_ADDR with an empty FIFO.
  - Response: done_o=1 on the next cycle, pass_o=0, exit_code_o=5.
- Watchdog:
  - Stimulus: max_cycles_i=100, no halt.
  - Response: done_o rises once cycle_count_o=100; timeout_o=1, pass_o=0. With max_cycles_i=0 and no halt, done_o stays 0 for 10000 cycles.
- Backpressure and overflow:
  - Stimulus: sig_ready_i=0, 18 signature stores with FIFO_DEPTH=16.
  - Response: overflow_o=1 and 16 words held. Then sig_ready_i=1 with a halt store: the first 16 words drain in order, done_o=1 only after the last pop.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, sig_ready_i=1, push 0x55 in the same cycle.
  - Response: overflow_o stays 0 and 0x55 is the last word popped.
- Reset mid-drain:
  - Stimulus: assert rst_n=0 asynchronously during DRAIN with 5 words queued.
  - Response: all outputs 0 immediately, sig_valid_o=0, state RUN after release.
